// File: rtl/spi_target_port_if.sv
// Pin and register-file bundle for the SPI target port.
// slave = the target itself; master = the SPI master plus register file around it.
interface spi_target_port_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
);
  logic              cs_i;
  logic              sclk_i;
  logic              sdi_i;
  logic              sdo_o;
  logic              sdo_oe_o;
  logic [ADDR_W-1:0] reg_addr_o;
  logic [DATA_W-1:0] reg_wdata_o;
  logic              reg_we_o;
  logic              reg_re_o;
  logic [DATA_W-1:0] reg_rdata_i;
  logic              busy_o;
  logic              frame_err_o;

  modport slave (
    input  cs_i, sclk_i, sdi_i, reg_rdata_i,
    output sdo_o, sdo_oe_o, reg_addr_o, reg_wdata_o, reg_we_o, reg_re_o,
    output busy_o, frame_err_o
  );

  modport master (
    output cs_i, sclk_i, sdi_i, reg_rdata_i,
    input  sdo_o, sdo_oe_o, reg_addr_o, reg_wdata_o, reg_we_o, reg_re_o,
    input  busy_o, frame_err_o
  );
endinterface

// File: rtl/spi_target_port.sv
// SPI mode-0 target for the AD9648-style configuration protocol: oversampled
// CS/SCLK/SDI, 16-bit instruction, byte data, register-file strobes.
module spi_target_port #(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk_i,
  input  logic                rst_clk_i,
  spi_target_port_if.slave    bus
);
  localparam int INSTR_W = ADDR_W + 3;
  localparam int CNT_W   = $clog2(INSTR_W + 1);

  typedef enum logic [2:0] {IDLE, INSTR, WR_DATA, RD_DATA, DONE} state_t;

  logic [SYNC_STAGES-1:0] cs_sync_reg, sclk_sync_reg, sdi_sync_reg, vld_reg;
  logic cs_prev_reg, sclk_prev_reg, lock_reg;
  logic cs_s, sclk_s, sdi_s, sclk_rise, sclk_fall, cs_fall;

  // lock_reg hides a frame already in progress at reset until CS is seen high.
  always_ff @(posedge clk_i) begin
    if (rst_clk_i) begin
      cs_sync_reg   <= '1;
      sclk_sync_reg <= '0;
      sdi_sync_reg  <= '0;
      vld_reg       <= '0;
      cs_prev_reg   <= 1'b1;
      sclk_prev_reg <= 1'b0;
      lock_reg      <= 1'b1;
    end else begin
      cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], bus.cs_i};
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], bus.sclk_i};
      sdi_sync_reg  <= {sdi_sync_reg[SYNC_STAGES-2:0], bus.sdi_i};
      vld_reg       <= {vld_reg[SYNC_STAGES-2:0], 1'b1};
      cs_prev_reg   <= cs_s;
      sclk_prev_reg <= sclk_s;
      if (&vld_reg && cs_s)
        lock_reg <= 1'b0;
    end
  end

  assign cs_s      = cs_sync_reg[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_reg[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync_reg[SYNC_STAGES-1];
  assign sclk_rise = !cs_s && sclk_s && !sclk_prev_reg;
  assign sclk_fall = !cs_s && !sclk_s && sclk_prev_reg;
  assign cs_fall   = !lock_reg && cs_prev_reg && !cs_s;

  state_t              state_reg;
  logic [CNT_W-1:0]    bit_cnt_reg;
  logic [INSTR_W-2:0]  instr_sh_reg;
  logic [DATA_W-2:0]   byte_sh_reg;
  logic [DATA_W-1:0]   nxt_reg, sdo_sh_reg;
  logic                nxt_vld_reg, stream_reg;
  logic [1:0]          bytes_left_reg;
  logic [ADDR_W-1:0]   addr_reg, reg_addr_reg;
  logic [DATA_W-1:0]   reg_wdata_reg;
  logic                sdo_reg, sdo_oe_reg, we_reg, re_reg, busy_reg, frame_err_reg;
  logic [INSTR_W-1:0]  instr_word;
  logic [DATA_W-1:0]   data_byte;
  logic                last_byte;

  assign instr_word = {instr_sh_reg, sdi_s};
  assign data_byte  = {byte_sh_reg, sdi_s};
  assign last_byte  = !stream_reg && (bytes_left_reg == 2'd1);

  always_ff @(posedge clk_i) begin
    if (rst_clk_i) begin
      state_reg      <= IDLE;
      bit_cnt_reg    <= '0;
      instr_sh_reg   <= '0;
      byte_sh_reg    <= '0;
      nxt_reg        <= '0;
      nxt_vld_reg    <= 1'b0;
      sdo_sh_reg     <= '0;
      stream_reg     <= 1'b0;
      bytes_left_reg <= '0;
      addr_reg       <= '0;
      reg_addr_reg   <= '0;
      reg_wdata_reg  <= '0;
      sdo_reg        <= 1'b0;
      sdo_oe_reg     <= 1'b0;
      we_reg         <= 1'b0;
      re_reg         <= 1'b0;
      busy_reg       <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      we_reg        <= 1'b0;
      re_reg        <= 1'b0;
      frame_err_reg <= 1'b0;
      if (re_reg) begin
        nxt_reg     <= bus.reg_rdata_i;
        nxt_vld_reg <= 1'b1;
      end
      if (state_reg != IDLE && cs_s) begin
        // Any CS rise closes the frame; only a half-shifted word counts as an abort.
        frame_err_reg <= (state_reg == INSTR) ||
                         ((state_reg == WR_DATA || state_reg == RD_DATA) && bit_cnt_reg != '0);
        state_reg     <= IDLE;
        busy_reg      <= 1'b0;
        sdo_oe_reg    <= 1'b0;
        sdo_reg       <= 1'b0;
        nxt_vld_reg   <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: if (cs_fall) begin
            state_reg   <= INSTR;
            bit_cnt_reg <= '0;
            busy_reg    <= 1'b1;
          end
          INSTR: if (sclk_rise) begin
            instr_sh_reg <= instr_word[INSTR_W-2:0];
            bit_cnt_reg  <= bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == CNT_W'(INSTR_W - 1)) begin
              bit_cnt_reg    <= '0;
              stream_reg     <= &instr_word[INSTR_W-2 -: 2];
              bytes_left_reg <= instr_word[INSTR_W-2 -: 2] + 2'd1;
              reg_addr_reg   <= instr_word[ADDR_W-1:0];
              if (instr_word[INSTR_W-1]) begin
                state_reg <= RD_DATA;
                re_reg    <= 1'b1;
                addr_reg  <= instr_word[ADDR_W-1:0] - ADDR_W'(1);
              end else begin
                state_reg <= WR_DATA;
                addr_reg  <= instr_word[ADDR_W-1:0];
              end
            end
          end
          WR_DATA: if (sclk_rise) begin
            byte_sh_reg <= data_byte[DATA_W-2:0];
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == CNT_W'(DATA_W - 1)) begin
              bit_cnt_reg    <= '0;
              we_reg         <= 1'b1;
              reg_wdata_reg  <= data_byte;
              reg_addr_reg   <= addr_reg;
              addr_reg       <= addr_reg - ADDR_W'(1);
              bytes_left_reg <= bytes_left_reg - 2'd1;
              if (last_byte)
                state_reg <= DONE;
            end
          end
          RD_DATA: begin
            if (sclk_fall) begin
              sdo_oe_reg <= 1'b1;
              if (nxt_vld_reg) begin
                sdo_reg     <= nxt_reg[DATA_W-1];
                sdo_sh_reg  <= {nxt_reg[DATA_W-2:0], 1'b0};
                nxt_vld_reg <= 1'b0;
              end else begin
                sdo_reg    <= sdo_sh_reg[DATA_W-1];
                sdo_sh_reg <= {sdo_sh_reg[DATA_W-2:0], 1'b0};
              end
            end
            if (sclk_rise) begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
              if (bit_cnt_reg == CNT_W'(DATA_W - 1)) begin
                bit_cnt_reg <= '0;
                if (last_byte) begin
                  state_reg <= DONE;
                end else begin
                  // Prefetch so the next byte is ready for the coming fall edge.
                  re_reg         <= 1'b1;
                  reg_addr_reg   <= addr_reg;
                  addr_reg       <= addr_reg - ADDR_W'(1);
                  bytes_left_reg <= bytes_left_reg - 2'd1;
                end
              end
            end
          end
          DONE: if (sclk_fall) begin
            sdo_oe_reg <= 1'b0;
            sdo_reg    <= 1'b0;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign bus.sdo_o       = sdo_reg;
  assign bus.sdo_oe_o    = sdo_oe_reg;
  assign bus.reg_addr_o  = reg_addr_reg;
  assign bus.reg_wdata_o = reg_wdata_reg;
  assign bus.reg_we_o    = we_reg;
  assign bus.reg_re_o    = re_reg;
  assign bus.busy_o      = busy_reg;
  assign bus.frame_err_o = frame_err_reg;
endmodule

// File: tb/tb_spi_target_port.sv
// Bench for spi_target_port: directed frames plus random frames, each checked
// against a frame-level model of strobes, SDO bytes, SDO enable and abort pulses.
module tb_spi_target_port;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_target_port_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  spi_target_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
    .clk_i     (clk),
    .rst_clk_i (rst),
    .bus       (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  int         we_addr_q[$], we_data_q[$], re_addr_q[$];
  bit         sdo_q[$], oe_q[$];
  int         err_pulses;
  logic [7:0] key;
  logic [7:0] wr_bytes[0:7];

  // Register file model: byte at address a is key XOR the low address byte.
  function automatic logic [7:0] mem_byte(input int a);
    return key ^ a[7:0];
  endfunction

  function automatic int outs();
    return int'({bus.sdo_o, bus.sdo_oe_o, bus.reg_addr_o, bus.reg_wdata_o,
                 bus.reg_we_o, bus.reg_re_o, bus.busy_o, bus.frame_err_o});
  endfunction

  // Read data is valid only in the cycle after reg_re_o; garbage otherwise.
  always @(negedge clk) begin
    if (bus.reg_we_o) begin
      we_addr_q.push_back(int'(bus.reg_addr_o));
      we_data_q.push_back(int'(bus.reg_wdata_o));
    end
    if (bus.reg_re_o) begin
      re_addr_q.push_back(int'(bus.reg_addr_o));
      bus.reg_rdata_i = mem_byte(int'(bus.reg_addr_o));
    end else begin
      bus.reg_rdata_i = 8'($urandom);
    end
    if (bus.frame_err_o) err_pulses++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One CS-low window with nbits SCLK pulses; rst_at >= 0 pulses reset after that bit.
  task automatic run_frame(input logic [15:0] instr, input int nbits, input int rst_at);
    int d, due, start, full, nb, n_we, n_re, bad_oe;
    bit rd, stream, exp_err, exp_oe;
    logic [7:0] v;
    we_addr_q.delete(); we_data_q.delete(); re_addr_q.delete();
    sdo_q.delete(); oe_q.delete();
    err_pulses = 0;
    rd     = instr[15];
    stream = (instr[14:13] == 2'b11);
    due    = int'(instr[14:13]) + 1;
    start  = int'(instr[12:0]);
    d      = nbits - 16;

    bus.cs_i = 1'b0;
    wait_clk(6);
    for (int b = 0; b < nbits; b++) begin
      bus.sdi_i = (b < 16) ? instr[15-b] : wr_bytes[(b-16)/8][7-((b-16)%8)];
      wait_clk(5);
      if (b == 0 && rst_at < 0) check_eq("busy_in_frame", int'(bus.busy_o), 1);
      oe_q.push_back(bus.sdo_oe_o);
      sdo_q.push_back(bus.sdo_o);
      bus.sclk_i = 1'b1;
      wait_clk(5);
      bus.sclk_i = 1'b0;
      if (b == rst_at) begin
        rst = 1'b1;
        wait_clk(1);
        check_eq("outs_mid_reset", outs(), 0);
        wait_clk(1);
        rst = 1'b0;
      end
    end
    wait_clk(5);
    bus.cs_i = 1'b1;
    wait_clk(12);
    check_eq("busy_after_cs", int'(bus.busy_o), 0);
    check_eq("oe_after_cs", int'(bus.sdo_oe_o), 0);

    full = (d > 0) ? d / 8 : 0;
    nb   = stream ? full : ((full < due) ? full : due);
    if (rst_at >= 0) begin
      exp_err = 1'b0; n_we = 0; n_re = 0;
    end else begin
      exp_err = (nbits < 16) ? 1'b1 : ((stream || d < due * 8) && (d % 8 != 0));
      n_we = (!rd && nbits >= 16) ? nb : 0;
      n_re = 0;
      if (rd && nbits >= 16) begin
        n_re = 1;
        for (int k = 1; k <= nb; k++)
          if (stream || k < due) n_re++;
      end
    end
    check_eq("frame_err_pulses", err_pulses, int'(exp_err));
    check_eq("we_count", we_addr_q.size(), n_we);
    for (int k = 0; k < n_we && k < we_addr_q.size(); k++) begin
      check_eq("we_addr", we_addr_q[k], (start - k) & 'h1FFF);
      check_eq("we_data", we_data_q[k], int'(wr_bytes[k]));
    end
    check_eq("re_count", re_addr_q.size(), n_re);
    for (int k = 0; k < n_re && k < re_addr_q.size(); k++)
      check_eq("re_addr", re_addr_q[k], (start - k) & 'h1FFF);
    if (rd && rst_at < 0) begin
      for (int k = 0; k < nb; k++) begin
        v = '0;
        for (int i = 0; i < 8; i++) v = {v[6:0], sdo_q[16 + 8*k + i]};
        check_eq("sdo_byte", int'(v), int'(mem_byte((start - k) & 'h1FFF)));
      end
    end
    bad_oe = -1;
    for (int b = nbits - 1; b >= 0; b--) begin
      exp_oe = (rst_at < 0) && rd && b >= 16 && (stream || b - 16 < due * 8);
      if (oe_q[b] != exp_oe) bad_oe = b;
    end
    check_eq("oe_first_bad_bit", bad_oe, -1);
    $display("frame instr=0x%04h bits=%0d rst_at=%0d we=%0d re=%0d err=%0d", instr, nbits,
             rst_at, we_addr_q.size(), re_addr_q.size(), err_pulses);
  endtask

  initial begin
    logic        rw;
    logic [1:0]  w;
    logic [12:0] st;
    int          r, due_bits, nbits;
    bus.cs_i = 1'b1;
    bus.sclk_i = 1'b0;
    bus.sdi_i = 1'b0;
    key = 8'h00;
    wait_clk(3);
    check_eq("outs_reset", outs(), 0);
    rst = 1'b0;
    wait_clk(8);

    wr_bytes[0] = 8'hA5;
    run_frame(16'h0014, 24, -1);
    wr_bytes[0] = 8'h11; wr_bytes[1] = 8'h22; wr_bytes[2] = 8'h33; wr_bytes[3] = 8'hC3;
    run_frame(16'h4008, 48, -1);
    key = 8'h3D;
    run_frame(16'h8001, 24, -1);
    key = 8'h00;
    run_frame(16'hE000, 40, -1);
    wr_bytes[0] = 8'hFF;
    run_frame(16'h0010, 21, -1);
    wr_bytes[0] = 8'h5A;
    run_frame(16'h0002, 24, -1);
    run_frame(16'h0020, 24, 5);
    wr_bytes[0] = 8'h96;
    run_frame(16'h0003, 24, -1);
    run_frame(16'h8005, 10, -1);

    for (int f = 0; f < 30; f++) begin
      rw  = 1'($urandom_range(0, 1));
      w   = 2'($urandom_range(0, 3));
      st  = 13'($urandom_range(0, 8191));
      key = 8'($urandom);
      for (int i = 0; i < 8; i++) wr_bytes[i] = 8'($urandom);
      due_bits = (w == 2'b11) ? 8 * $urandom_range(1, 4) : 8 * (int'(w) + 1);
      r = $urandom_range(0, 9);
      if (r == 0)      nbits = $urandom_range(0, 15);
      else if (r <= 6) nbits = 16 + due_bits;
      else if (r <= 8) nbits = 16 + $urandom_range(0, due_bits + 8);
      else             nbits = 16 + due_bits + 8;
      run_frame({rw, w, st}, nbits, (f % 10 == 9) ? $urandom_range(0, 15) : -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
